subservient_sram_arb: RTL and testbench

Dual-requester arbiter and width adapter between the subservient core's 8-bit SRAM interface, the 32-bit debug Wishbone port, and the 1kB OpenRAM 1rw1r macro. Port 0 is write-only and port 1 is read-only. The CPU always wins because the core cannot stall. Debug accesses are sequenced by a small FSM into idle port cycles, with a starvation timeout that terminates them with an error.

---
 rtl/subservient_sram_arb.sv | 162 ++++++++++++++++
 tb/tb_subservient_sram_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subservient_sram_arb.sv
// Arbiter/width adapter: 8-bit CPU and 32-bit debug Wishbone onto a 1rw1r SRAM macro.
// CPU strobes always win; debug accesses slot into idle port cycles or time out.
module subservient_sram_arb #(
    parameter int memsize = 1024,
    parameter int aw      = $clog2(memsize),
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [aw-1:0] i_cpu_waddr,
    input  logic [7:0]    i_cpu_wdata,
    input  logic          i_cpu_wen,
    input  logic [aw-1:0] i_cpu_raddr,
    input  logic          i_cpu_ren,
    output logic [7:0]    o_cpu_rdata,
    input  logic [31:0]   i_wb_dbg_adr,
    input  logic [31:0]   i_wb_dbg_dat,
    input  logic [3:0]    i_wb_dbg_sel,
    input  logic          i_wb_dbg_we,
    input  logic          i_wb_dbg_stb,
    output logic [31:0]   o_wb_dbg_rdt,
    output logic          o_wb_dbg_ack,
    output logic          o_wb_dbg_err,
    output logic          o_sram_csb0,
    output logic          o_sram_web0,
    output logic [3:0]    o_sram_wmask0,
    output logic [aw-3:0] o_sram_addr0,
    output logic [31:0]   o_sram_din0,
    output logic          o_sram_csb1,
    output logic [aw-3:0] o_sram_addr1,
    input  logic [31:0]   i_sram_dout1
);

    typedef enum logic [2:0] {IDLE, WR, RD, RDW, RESP} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [aw-3:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    bsel_q, bsel_d;
    logic [31:0]   rdt_q, rdt_d;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{i_wb_dbg_adr[31:aw], i_wb_dbg_adr[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            bsel_q  <= '0;
            rdt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            bsel_q  <= bsel_d;
            rdt_q   <= rdt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdt_d   = rdt_q;
        bsel_d  = i_cpu_ren ? i_cpu_raddr[1:0] : bsel_q;
        case (state_q)
            IDLE: begin
                if (i_wb_dbg_stb) begin
                    adr_d   = i_wb_dbg_adr[aw-1:2];
                    dat_d   = i_wb_dbg_dat;
                    sel_d   = i_wb_dbg_sel;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = i_wb_dbg_we ? WR : RD;
                end
            end
            WR: begin
                if (!i_cpu_wen) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RD: begin
                if (!i_cpu_ren) begin
                    state_d = RDW;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RDW: begin
                rdt_d   = i_sram_dout1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port 0: CPU write has priority; the debug write only issues when the CPU is idle.
    always_comb begin
        o_sram_csb0   = 1'b1;
        o_sram_wmask0 = '0;
        o_sram_addr0  = '0;
        o_sram_din0   = '0;
        if (i_cpu_wen) begin
            o_sram_csb0   = 1'b0;
            o_sram_addr0  = i_cpu_waddr[aw-1:2];
            o_sram_wmask0 = 4'b0001 << i_cpu_waddr[1:0];
            o_sram_din0   = {4{i_cpu_wdata}};
        end else if (state_q == WR) begin
            o_sram_csb0   = 1'b0;
            o_sram_addr0  = adr_q;
            o_sram_wmask0 = sel_q;
            o_sram_din0   = dat_q;
        end
        if (!i_rst_n) o_sram_csb0 = 1'b1;
    end

    always_comb begin
        o_sram_csb1  = 1'b1;
        o_sram_addr1 = '0;
        if (i_cpu_ren) begin
            o_sram_csb1  = 1'b0;
            o_sram_addr1 = i_cpu_raddr[aw-1:2];
        end else if (state_q == RD) begin
            o_sram_csb1  = 1'b0;
            o_sram_addr1 = adr_q;
        end
        if (!i_rst_n) o_sram_csb1 = 1'b1;
    end

    assign o_sram_web0  = 1'b0;
    assign o_cpu_rdata  = i_sram_dout1[{bsel_q, 3'b000} +: 8];
    assign o_wb_dbg_rdt = rdt_q;
    assign o_wb_dbg_ack = (state_q == RESP) && !err_q;
    assign o_wb_dbg_err = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Scoreboard bench: drivers push expected port/response events, one negedge monitor checks them.
module tb_subservient_sram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  cpu_waddr, cpu_raddr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_wen, cpu_ren;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_ack, wb_err;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0, dout1;

    logic [9:0]  t_raddr;
    logic        t_ren, t_stb;
    logic [31:0] t_adr, t_rdt;
    logic        t_ack, t_err, t_csb0, t_csb1;
    logic [7:0]  t_addr1;
    logic [31:0] t_dout1;
    logic [7:0]  t_unused_rdata;
    logic        t_unused_web0;
    logic [3:0]  t_unused_wmask0;
    logic [7:0]  t_unused_addr0;
    logic [31:0] t_unused_din0;

    subservient_sram_arb #(.memsize(1024)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
        .i_cpu_raddr(cpu_raddr), .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
        .i_wb_dbg_adr(wb_adr), .i_wb_dbg_dat(wb_dat), .i_wb_dbg_sel(wb_sel),
        .i_wb_dbg_we(wb_we), .i_wb_dbg_stb(wb_stb), .o_wb_dbg_rdt(wb_rdt),
        .o_wb_dbg_ack(wb_ack), .o_wb_dbg_err(wb_err),
        .o_sram_csb0(csb0), .o_sram_web0(web0), .o_sram_wmask0(wmask0),
        .o_sram_addr0(addr0), .o_sram_din0(din0),
        .o_sram_csb1(csb1), .o_sram_addr1(addr1), .i_sram_dout1(dout1)
    );

    subservient_sram_arb #(.memsize(1024), .TIMEOUT(4)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_waddr(10'd0), .i_cpu_wdata(8'd0), .i_cpu_wen(1'b0),
        .i_cpu_raddr(t_raddr), .i_cpu_ren(t_ren), .o_cpu_rdata(t_unused_rdata),
        .i_wb_dbg_adr(t_adr), .i_wb_dbg_dat(32'hCAFEF00D), .i_wb_dbg_sel(4'hF),
        .i_wb_dbg_we(1'b0), .i_wb_dbg_stb(t_stb), .o_wb_dbg_rdt(t_rdt),
        .o_wb_dbg_ack(t_ack), .o_wb_dbg_err(t_err),
        .o_sram_csb0(t_csb0), .o_sram_web0(t_unused_web0), .o_sram_wmask0(t_unused_wmask0),
        .o_sram_addr0(t_unused_addr0), .o_sram_din0(t_unused_din0),
        .o_sram_csb1(t_csb1), .o_sram_addr1(t_addr1), .i_sram_dout1(t_dout1)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] din;
    } p0_t;

    typedef struct packed {
        logic        is_err;
        logic [31:0] cyc;
        logic        chk_rdt;
        logic [31:0] rdt;
    } dbg_t;

    p0_t        p0_q[$];
    logic [7:0] p1_q[$];
    logic [7:0] rd_q[$];
    dbg_t       dbg_q[$];
    dbg_t       t_q[$];

    logic [7:0] ref_mem [1024];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic t_phase = 1'b0;
    logic rd_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_pend <= cpu_ren & rst_n;

    // SRAM macro model: registered read port, masked write port; loaded from ref_mem on the first edge.
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    logic [31:0] nw;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int w = 0; w < 256; w++)
                mem[w] <= {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
            mem_loaded <= 1'b1;
        end else begin
            if (!csb1) dout1 <= mem[addr1];
            if (!csb0 && !web0) begin
                nw = mem[addr0];
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) nw[b*8 +: 8] = din0[b*8 +: 8];
                mem[addr0] <= nw;
            end
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] word_at(input logic [9:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    p0_t        m_e0;
    logic [7:0] m_e1, m_er;
    dbg_t       m_ed, m_et;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!csb0) begin
                chk("p0_expected", 64'(p0_q.size() != 0), 64'd1);
                if (p0_q.size() != 0) begin
                    m_e0 = p0_q.pop_front();
                    chk("p0_access", 64'({web0, addr0, wmask0, din0}), 64'({1'b0, m_e0}));
                end
            end
            if (!csb1) begin
                chk("p1_expected", 64'(p1_q.size() != 0), 64'd1);
                if (p1_q.size() != 0) begin
                    m_e1 = p1_q.pop_front();
                    chk("p1_addr", 64'(addr1), 64'(m_e1));
                end
            end
            if (rd_pend) begin
                chk("cpu_rd_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    m_er = rd_q.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(m_er));
                end
            end
            if (wb_ack || wb_err) begin
                chk("dbg_expected", 64'(dbg_q.size() != 0), 64'd1);
                if (dbg_q.size() != 0) begin
                    m_ed = dbg_q.pop_front();
                    chk("dbg_ack_err_cycle", 64'({wb_ack, wb_err, 32'(cyc)}),
                        64'({~m_ed.is_err, m_ed.is_err, m_ed.cyc}));
                    if (m_ed.chk_rdt) chk("dbg_rdt", 64'(wb_rdt), 64'(m_ed.rdt));
                end
            end
            if (t_phase) begin
                if (!t_csb1) chk("t_p1_cpu_only", 64'(t_addr1), 64'(t_raddr[9:2]));
                chk("t_p0_idle", 64'(t_csb0), 64'd1);
                if (t_ack || t_err) begin
                    chk("t_expected", 64'(t_q.size() != 0), 64'd1);
                    if (t_q.size() != 0) begin
                        m_et = t_q.pop_front();
                        chk("t_ack_err_cycle", 64'({t_ack, t_err, 32'(cyc)}),
                            64'({~m_et.is_err, m_et.is_err, m_et.cyc}));
                        chk("t_rdt", 64'(t_rdt), 64'(m_et.rdt));
                    end
                end
            end
        end
    end

    task automatic cpu_set(input int op, input logic [9:0] a, input logic [7:0] d);
        p0_t e;
        cpu_wen   = (op == 1);
        cpu_ren   = (op == 2);
        cpu_waddr = a;
        cpu_raddr = a;
        cpu_wdata = d;
        if (op == 1) begin
            ref_mem[a] = d;
            e.addr = a[9:2];
            e.mask = 4'b0001 << a[1:0];
            e.din  = {4{d}};
            p0_q.push_back(e);
        end
        if (op == 2) begin
            rd_q.push_back(ref_mem[a]);
            p1_q.push_back(a[9:2]);
        end
    endtask

    task automatic cpu_cycle(input int op, input logic [9:0] a, input logic [7:0] d);
        cpu_set(op, a, d);
        @(posedge clk); #1;
    endtask

    task automatic cpu_random(input int n);
        for (int i = 0; i < n; i++)
            cpu_cycle(int'($urandom_range(0, 2)), 10'($urandom_range(0, 1023)), 8'($urandom));
        cpu_set(0, 10'd0, 8'd0);
    endtask

    // Debug access with the CPU holding the conflicting strobe for blk cycles after acceptance.
    task automatic dbg(input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int blk);
        int   e;
        int   n;
        p0_t  p;
        dbg_t r;
        wb_adr = 32'(adr); wb_dat = dat; wb_sel = sel; wb_we = we; wb_stb = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        wb_stb = 1'b0; wb_adr = $urandom; wb_dat = $urandom; wb_sel = 4'($urandom);
        for (int i = 0; i < blk; i++)
            cpu_cycle(we ? 1 : 2, 10'($urandom_range(0, 1023)), 8'($urandom));
        cpu_set(0, 10'd0, 8'd0);
        r.is_err = 1'b0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[{adr[9:2], 2'(b)}] = dat[b*8 +: 8];
            p.addr = adr[9:2]; p.mask = sel; p.din = dat;
            p0_q.push_back(p);
            r.cyc = 32'(e + 1 + blk); r.chk_rdt = 1'b0; r.rdt = '0;
        end else begin
            p1_q.push_back(adr[9:2]);
            r.cyc = 32'(e + 2 + blk); r.chk_rdt = 1'b1; r.rdt = word_at(adr);
        end
        dbg_q.push_back(r);
        n = 0;
        while (dbg_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dbg_done", 64'(dbg_q.size()), 64'd0);
        dbg_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        dbg_t tr;
        int   e;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        rst_n = 1'b0;
        cpu_wen = 1'b1; cpu_ren = 1'b1; cpu_waddr = 10'h3; cpu_raddr = 10'h7; cpu_wdata = 8'h5A;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0;
        t_raddr = 10'd0; t_ren = 1'b0; t_stb = 1'b0; t_adr = '0; t_dout1 = 32'h12345678;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ack", 64'(wb_ack), 64'd0);
        chk("rst_err", 64'(wb_err), 64'd0);
        chk("rst_rdt", 64'(wb_rdt), 64'd0);
        chk("rst_csb0", 64'(csb0), 64'd1);
        chk("rst_csb1", 64'(csb1), 64'd1);
        cpu_set(0, 10'd0, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        cpu_cycle(1, 10'h00D, 8'hA5);
        cpu_cycle(2, 10'h00D, 8'h00);
        cpu_set(0, 10'd0, 8'd0);

        dbg(10'h040, 32'hDEADBEEF, 4'hF, 1'b1, 0);
        dbg(10'h040, 32'h0, 4'hF, 1'b0, 0);
        for (int i = 0; i < 4; i++) cpu_cycle(2, 10'(10'h040 + i), 8'h00);
        cpu_set(0, 10'd0, 8'd0);

        dbg(10'h080, 32'h13579BDF, 4'hF, 1'b1, 5);
        dbg(10'h080, 32'h0, 4'hF, 1'b0, 3);

        dbg(10'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 0);
        dbg(10'h100, 32'h00110000, 4'b0100, 1'b1, 0);
        dbg(10'h100, 32'h0, 4'hF, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            cpu_random(int'($urandom_range(0, 4)));
            dbg(10'($urandom_range(0, 1023)), $urandom, 4'($urandom), 1'($urandom),
                int'($urandom_range(0, 6)));
        end

        // Reset lands while the debug read sits in RDW.
        wb_adr = 32'h40; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        p1_q.push_back(8'h10);
        @(posedge clk); #3;
        rst_n = 1'b0; cpu_wen = 1'b1; cpu_ren = 1'b1;
        #1;
        chk("mid_rst_ack", 64'(wb_ack), 64'd0);
        chk("mid_rst_err", 64'(wb_err), 64'd0);
        chk("mid_rst_rdt", 64'(wb_rdt), 64'd0);
        chk("mid_rst_csb0", 64'(csb0), 64'd1);
        chk("mid_rst_csb1", 64'(csb1), 64'd1);
        cpu_set(0, 10'd0, 8'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        dbg(10'h041, 32'h0, 4'hF, 1'b0, 0);
        cpu_cycle(2, 10'h042, 8'h00);
        cpu_set(0, 10'd0, 8'd0);

        t_raddr = 10'h3F0; t_ren = 1'b1; t_phase = 1'b1;
        t_adr = 32'h40; t_stb = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        t_stb = 1'b0;
        tr.is_err = 1'b1; tr.cyc = 32'(e + 4); tr.chk_rdt = 1'b1; tr.rdt = '0;
        t_q.push_back(tr);
        repeat (12) begin @(posedge clk); #1; end
        chk("t_done", 64'(t_q.size()), 64'd0);
        t_phase = 1'b0; t_ren = 1'b0;

        repeat (3) begin @(posedge clk); #1; end
        chk("p0_drained", 64'(p0_q.size()), 64'd0);
        chk("p1_drained", 64'(p1_q.size()), 64'd0);
        chk("rd_drained", 64'(rd_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
